// File: rtl/jt12_logsin_lut.sv
`default_nettype none
// ============================================================================
//  Module      : jt12_logsin_lut
//  Description : Writable quarter-wave log-sine table for the operator phase
//                path. The full wave is rebuilt by mirroring the index in the
//                second quarter of each half and taking the sign from the
//                phase MSB. Three-stage clk_en-gated pipeline with valid
//                tracking, post-reset table clear and a runtime write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt12_logsin_lut #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 12,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clk_en,
    input  logic [ADDR_W+1:0] i_phase,
    input  logic              i_in_valid,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_logsin,
    output logic              o_sign,
    output logic              o_out_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Without a clear pass the table is usable straight out of reset.
    localparam state_t c_RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                r_ready;

    // Table write port, shared between the clear sweep and the user port
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Address decode
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_sign;

    // Pipeline stages
    logic [ADDR_W-1:0]   r_addr1;
    logic                r_sign1;
    logic                r_v1;
    logic [DATA_W-1:0]   r_rdata2;
    logic                r_sign2;
    logic                r_v2;
    logic [DATA_W-1:0]   r_logsin3;
    logic                r_sign3;
    logic                r_v3;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    // State register; ready follows the state one edge later so that the
    // no-clear variant still reports not-ready on the reset edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_RST_STATE;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_ready   <= (w_state_nxt == ST_READY);
        end
    end

    // Next state and table write-port steering. The clear sweep runs on
    // every edge regardless of clk_en and owns the write port while active.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_mem_we      = 1'b0;
        w_mem_waddr   = i_wr_addr;
        w_mem_wdata   = i_wr_data;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we      = ~rst;
                w_mem_waddr   = r_clr_cnt;
                w_mem_wdata   = '0;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_mem_we = i_wr_en & ~rst;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Quarter-wave mirroring: the second quarter of each half reads the
    // table backwards, and the top bit selects the negative half.
    always_comb begin
        w_idx  = i_phase[ADDR_W-1:0];
        w_addr = i_phase[ADDR_W] ? ~w_idx : w_idx;
        w_sign = i_phase[ADDR_W+1];
    end

    // Stage 1: register decoded address, sign and qualified valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr1 <= '0;
            r_sign1 <= 1'b0;
            r_v1    <= 1'b0;
        end else if (i_clk_en) begin
            r_addr1 <= w_addr;
            r_sign1 <= w_sign;
            r_v1    <= i_in_valid & r_ready;
        end
    end

    // Table RAM: synchronous write plus registered read (stage 2 data).
    // Both use non-blocking updates, so a same-address collision returns
    // the previous contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        if (i_clk_en) begin
            r_rdata2 <= r_mem[r_addr1];
        end
    end

    // Stage 2: carry sign and valid alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign2 <= 1'b0;
            r_v2    <= 1'b0;
        end else if (i_clk_en) begin
            r_sign2 <= r_sign1;
            r_v2    <= r_v1;
        end
    end

    // Stage 3: output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_logsin3 <= '0;
            r_sign3   <= 1'b0;
            r_v3      <= 1'b0;
        end else if (i_clk_en) begin
            r_logsin3 <= r_rdata2;
            r_sign3   <= r_sign2;
            r_v3      <= r_v2;
        end
    end

    assign o_ready     = r_ready;
    assign o_logsin    = r_logsin3;
    assign o_sign      = r_sign3;
    assign o_out_valid = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_jt12_logsin_lut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt12_logsin_lut
//  Description : Directed, table-driven bench for jt12_logsin_lut. One
//                instance clears on reset, a second keeps its contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_logsin_lut;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    // Clearing instance
    logic              rst, clk_en, in_valid, wr_en;
    logic [ADDR_W+1:0] phase;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ready, sign, out_valid;
    logic [DATA_W-1:0] logsin;
    // Non-clearing instance
    logic              b_rst, b_clk_en, b_in_valid, b_wr_en;
    logic [ADDR_W+1:0] b_phase;
    logic [ADDR_W-1:0] b_wr_addr;
    logic [DATA_W-1:0] b_wr_data;
    logic              b_ready, b_sign, b_out_valid;
    logic [DATA_W-1:0] b_logsin;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jt12_logsin_lut #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_ON_RST(1)) u_dut (
        .clk(clk), .rst(rst), .i_clk_en(clk_en), .i_phase(phase),
        .i_in_valid(in_valid), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_ready(ready), .o_logsin(logsin),
        .o_sign(sign), .o_out_valid(out_valid)
    );

    jt12_logsin_lut #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_ON_RST(0)) u_dut_keep (
        .clk(clk), .rst(b_rst), .i_clk_en(b_clk_en), .i_phase(b_phase),
        .i_in_valid(b_in_valid), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
        .i_wr_data(b_wr_data), .o_ready(b_ready), .o_logsin(b_logsin),
        .o_sign(b_sign), .o_out_valid(b_out_valid)
    );

    typedef struct {
        logic [ADDR_W+1:0] ph;
        logic [DATA_W-1:0] exp_logsin;
        logic              exp_sign;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    vec_t vecs [11];
    wr_t  wrs  [3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Single lookup on the clearing instance with clk_en held high.
    task automatic lookup(input string name, input logic [ADDR_W+1:0] ph,
                          input logic [DATA_W-1:0] exp_l, input logic exp_s);
        phase    = ph;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_logsin"}, 32'(logsin), 32'(exp_l));
        chk({name, "_sign"}, 32'(sign), 32'(exp_s));
    endtask

    task automatic b_lookup(input string name, input logic [ADDR_W+1:0] ph,
                            input logic [DATA_W-1:0] exp_l);
        b_phase    = ph;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        step();
        step();
        chk({name, "_valid"}, 32'(b_out_valid), 32'd1);
        chk({name, "_logsin"}, 32'(b_logsin), 32'(exp_l));
    endtask

    initial begin
        int bad_rdy;
        int bad_ov;

        wrs[0] = '{8'h05, 12'h123};
        wrs[1] = '{8'hFF, 12'hFFF};
        wrs[2] = '{8'h00, 12'h001};

        vecs[0]  = '{10'h005, 12'h123, 1'b0};
        vecs[1]  = '{10'h1FA, 12'h123, 1'b0};
        vecs[2]  = '{10'h205, 12'h123, 1'b1};
        vecs[3]  = '{10'h3FA, 12'h123, 1'b1};
        vecs[4]  = '{10'h000, 12'h001, 1'b0};
        vecs[5]  = '{10'h0FF, 12'hFFF, 1'b0};
        vecs[6]  = '{10'h100, 12'hFFF, 1'b0};
        vecs[7]  = '{10'h1FF, 12'h001, 1'b0};
        vecs[8]  = '{10'h300, 12'hFFF, 1'b1};
        vecs[9]  = '{10'h3FF, 12'h001, 1'b1};
        vecs[10] = '{10'h2FF, 12'hFFF, 1'b1};

        rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; wr_en = 1'b0;
        phase = '0; wr_addr = '0; wr_data = '0;
        b_rst = 1'b1; b_clk_en = 1'b1; b_in_valid = 1'b0; b_wr_en = 1'b0;
        b_phase = '0; b_wr_addr = '0; b_wr_data = '0;

        // ---- Reset state and clear duration ----
        step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_logsin", 32'(logsin), 32'd0);
        chk("rst_sign", 32'(sign), 32'd0);

        rst = 1'b0; in_valid = 1'b1; phase = 10'h005;
        bad_rdy = 0; bad_ov = 0;
        for (int e = 1; e <= 255; e++) begin
            step();
            if (ready !== 1'b0) bad_rdy++;
            if (out_valid !== 1'b0) bad_ov++;
        end
        in_valid = 1'b0;
        step();
        chk("clear_ready_low_edges", 32'(bad_rdy), 32'd0);
        chk("clear_ready_at_256", 32'(ready), 32'd1);
        for (int e = 0; e < 3; e++) begin
            if (out_valid !== 1'b0) bad_ov++;
            step();
        end
        chk("clear_valid_low_edges", 32'(bad_ov), 32'd0);

        // ---- Load table and run back-to-back vectors ----
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = wrs[i].addr; wr_data = wrs[i].data;
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i < 11) begin
                phase = vecs[i].ph; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk($sformatf("vec%0d_valid", i - 2), 32'(out_valid), 32'd1);
                chk($sformatf("vec%0d_logsin", i - 2), 32'(logsin), 32'(vecs[i-2].exp_logsin));
                chk($sformatf("vec%0d_sign", i - 2), 32'(sign), 32'(vecs[i-2].exp_sign));
            end
        end
        step();
        chk("vec_drain_valid", 32'(out_valid), 32'd0);

        // ---- clk_en one cycle in three ----
        phase = 10'h005; in_valid = 1'b1; clk_en = 1'b0;
        step(); step();
        clk_en = 1'b1; step();                      // E0
        in_valid = 1'b0; clk_en = 1'b0;
        step(); step();
        chk("cen_hold_invalid", 32'(out_valid), 32'd0);
        clk_en = 1'b1; step();                      // E1
        chk("cen_e1_invalid", 32'(out_valid), 32'd0);
        clk_en = 1'b0; step(); step();
        clk_en = 1'b1; step();                      // E2
        chk("cen_e2_valid", 32'(out_valid), 32'd1);
        chk("cen_e2_logsin", 32'(logsin), 32'h123);
        clk_en = 1'b0; step(); step();
        chk("cen_hold_valid", 32'(out_valid), 32'd1);
        chk("cen_hold_logsin", 32'(logsin), 32'h123);
        clk_en = 1'b1; step();
        chk("cen_after_valid", 32'(out_valid), 32'd0);

        // ---- Read/write collision ----
        phase = 10'h005; in_valid = 1'b1;
        step();
        in_valid = 1'b0; wr_en = 1'b1; wr_addr = 8'h05; wr_data = 12'h456;
        step();
        wr_en = 1'b0;
        step();
        chk("coll_old_valid", 32'(out_valid), 32'd1);
        chk("coll_old_logsin", 32'(logsin), 32'h123);
        lookup("coll_new", 10'h005, 12'h456, 1'b0);

        // ---- Reset with lookups in flight, restart, write during clear ----
        phase = 10'h005; in_valid = 1'b1;
        step(); step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        rst = 1'b0; wr_en = 1'b1; wr_addr = 8'h10; wr_data = 12'hABC;
        for (int e = 0; e < 100; e++) step();
        chk("midrst_clear_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad_rdy = 0; bad_ov = 0;
        for (int e = 1; e <= 255; e++) begin
            step();
            if (ready !== 1'b0) bad_rdy++;
            if (out_valid !== 1'b0) bad_ov++;
        end
        step();
        chk("reclear_ready_low_edges", 32'(bad_rdy), 32'd0);
        chk("reclear_valid_low_edges", 32'(bad_ov), 32'd0);
        chk("reclear_ready_at_256", 32'(ready), 32'd1);
        wr_en = 1'b0;
        lookup("cleared_05", 10'h005, 12'h000, 1'b0);
        lookup("cleared_10", 10'h010, 12'h000, 1'b0);
        lookup("cleared_ff", 10'h0FF, 12'h000, 1'b0);

        // ---- Non-clearing instance ----
        chk("keep_rst_ready", 32'(b_ready), 32'd0);
        chk("keep_rst_valid", 32'(b_out_valid), 32'd0);
        b_rst = 1'b0;
        step();
        chk("keep_ready_edge1", 32'(b_ready), 32'd1);
        b_wr_en = 1'b1; b_wr_addr = 8'h10; b_wr_data = 12'hABC;
        step();
        b_wr_en = 1'b0;
        b_lookup("keep_lookup", 10'h010, 12'hABC);
        b_rst = 1'b1;
        step();
        chk("keep_rst2_ready", 32'(b_ready), 32'd0);
        chk("keep_rst2_valid", 32'(b_out_valid), 32'd0);
        b_rst = 1'b0;
        step();
        chk("keep_ready2_edge1", 32'(b_ready), 32'd1);
        b_lookup("keep_survive", 10'h010, 12'hABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt12_logsin_lut.md
Name: jt12_logsin_lut

Overview:
- Parametrised, writable log-sine lookup for the operator phase path; successor to the fixed 32-entry phase ROM.
- Stores a quarter-wave table of 2^ADDR_W entries and reconstructs the full wave by mirroring the address and extracting the sign.
- 3-stage clk_en-gated pipeline with valid tracking. Post-reset table-clear state machine; runtime write port for table loading.

Parameters:
ADDR_W, 8, quarter-wave table address width; DEPTH = 2^ADDR_W; phase width = ADDR_W+2
DATA_W, 12, log-sine word width
CLR_ON_RST, 1, 1 = zero the table after reset; 0 = keep contents, ready immediately

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  pipeline advance enable; stages hold when low
phase  in  ADDR_W+2  operator phase; MSB = half, MSB-1 = quarter, rest = index
in_valid  in  1  phase qualifier
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write address
wr_data  in  DATA_W  table write data
ready  out  1  table cleared and usable
logsin  out  DATA_W  looked-up log-sine magnitude
sign  out  1  wave sign (1 = negative half)
out_valid  out  1  logsin/sign qualifier

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, logsin=0, sign=0, all stage valids=0, ready=0. State=CLEAR with counter=0 if CLR_ON_RST=1; otherwise state=READY, with ready=1 from the first edge after rst falls. Table RAM is not reset directly.
- CLEAR state:
  - Runs every clk edge, independent of clk_en. Writes 0 to table[counter], then counter++.
  - Writing DEPTH-1 moves the state to READY; ready=1 after the DEPTH-th edge following rst release.
  - wr_en and in_valid are ignored.
- rst during CLEAR restarts the clear at counter 0. rst during READY re-enters CLEAR when CLR_ON_RST=1.
- READY state: wr_en=1 writes wr_data to table[wr_addr] on the clk edge. Writes are not gated by clk_en.
- Address decode: idx = phase[ADDR_W-1:0]; addr = phase[ADDR_W] ? ~idx : idx; sign = phase[ADDR_W+1].
- Pipeline, advancing only on edges with clk_en=1:
  - S1 registers addr, sign, and v1 = in_valid & ready.
  - S2 registers table[addr], sign, v1.
  - S3 registers logsin, sign, out_valid.
  - Latency: the input sampled at enabled edge E0 appears at the outputs after enabled edge E2. One result per enabled edge, no bubbles.
- clk_en=0: all stage registers and outputs hold. A write may still occur on that edge.
- Read/write collision: when the S2 read and a write hit the same address on the same edge, the read returns the old data (read-before-write). The new data is visible to later reads.
- ready falling (rst) drops v1; in-flight data drains only if no reset. Reset clears every stage on that edge.
- out_valid=0 leaves logsin/sign holding their last values; only out_valid is contractual then.
- Table maps to single-clock synchronous RAM, one read plus one write port; no combinational read path.

Test Plan:
1. ADDR_W=8, CLR_ON_RST=1. Release rst, clk_en=1 -> ready=0 for edges 1..255, ready=1 after edge 256; out_valid=0 throughout, including with in_valid=1 during clear.
2. Write table[0x05]=0x123. Send phase 0x005, 0x1FA, 0x205, 0x3FA back-to-back with clk_en=1 -> outputs after the 3rd..6th enabled edges give logsin=0x123 each; sign=0,0,1,1; out_valid=1 for 4 consecutive cycles, then 0.
3. clk_en high one cycle in three, phase 0x005 -> result appears after the 3rd enabled edge (9 clk edges); outputs hold steady across disabled cycles.
4. Collision: write table[0x05]=0x456 on the same edge S2 reads address 5 -> that result is 0x123; the next lookup of 0x005 returns 0x456.
5. Reset mid-operation: assert rst with two lookups in flight and clear completed -> out_valid=0 next edge, ready=0, clear restarts; after ready, phase 0x005 returns 0x000. Assert rst again at clear count 100 -> ready still needs a full 256 edges.
6. wr_en=1 (addr 0x10, data 0xABC) during CLEAR -> ignored; lookup after ready returns 0x000. CLR_ON_RST=0 -> ready=1 after the first post-reset edge, and previously written table[0x10] survives rst.
